// File: rtl/pst_eval_sequencer.sv
// pst_eval_sequencer: walks the 64 squares of a captured board, one per cycle,
// looks up each occupied square in its piece map and accumulates a signed
// positional score (white positive, black negative, black squares rank-mirrored).
module pst_eval_sequencer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] board,
    input  logic [383:0] pawn_map,
    input  logic [383:0] knight_map,
    input  logic [383:0] bishop_map,
    input  logic [383:0] rook_map,
    input  logic [383:0] queen_map,
    input  logic [383:0] king_map,
    output logic         busy,
    output logic         done,
    output logic [12:0]  score
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [255:0]  board_q;
    logic [5:0]    sq;
    logic [12:0]   acc;
    logic [12:0]   term_q;
    logic          term_v;

    logic [3:0]    code;
    logic [2:0]    ptype;
    logic          black;
    logic [5:0]    idx;
    logic [8:0]    base;
    logic [383:0]  map_sel;
    logic [5:0]    entry;
    logic [12:0]   entry_ext;
    logic [12:0]   term_nx;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic: IDLE waits for start, SCAN runs through square 63, DRAIN is one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (sq == 6'd63) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage 1 term: decode the current square, pick the map entry and apply colour sign
    always_comb begin
        code      = board_q[{sq, 2'b00} +: 4];
        ptype     = code[2:0];
        black     = code[3];
        idx       = black ? (sq ^ 6'd56) : sq;
        base      = 9'(idx) * 9'd6;
        map_sel   = '0;
        case (ptype)
            3'd1:    map_sel = pawn_map;
            3'd2:    map_sel = knight_map;
            3'd3:    map_sel = bishop_map;
            3'd4:    map_sel = rook_map;
            3'd5:    map_sel = queen_map;
            3'd6:    map_sel = king_map;
            default: map_sel = '0;
        endcase
        entry     = map_sel[base +: 6];
        entry_ext = {{7{entry[5]}}, entry};
        if (ptype == 3'd0 || ptype == 3'd7) term_nx = '0;
        else if (black)                     term_nx = -entry_ext;
        else                                term_nx = entry_ext;
    end

    // Board snapshot taken on the accepting edge so later board changes cannot disturb a run
    always_ff @(posedge clk) begin
        if (state == IDLE && start) board_q <= board;
    end

    // Datapath and status: two-stage term/accumulate pipeline, final add in DRAIN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            score  <= '0;
            acc    <= '0;
            sq     <= '0;
            term_q <= '0;
            term_v <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sq     <= '0;
                        acc    <= '0;
                        term_v <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    term_q <= term_nx;
                    term_v <= 1'b1;
                    if (term_v) acc <= acc + term_q;
                    sq <= sq + 6'd1;
                end
                DRAIN: begin
                    score  <= acc + term_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    term_v <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
